// File: rtl/uart_receiver.sv
// uart_receiver: 16x-oversampled UART receive stage with majority-vote bit decisions
// and a valid/ready holding register that flags framing, parity and overrun errors.
module uart_receiver #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [DIV_WIDTH-1:0] baud_div,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun_err,
    output logic                 busy
);
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t               state_q;
    logic                 rx_m_q, rx_s_q, rx_s_dly_q;
    logic [DIV_WIDTH-1:0] div_q, div_d;
    logic                 tick, fall, decide, maj;
    logic [3:0]           scnt_q, bcnt_q;
    logic [1:0]           smp_q;
    logic [DATA_BITS-1:0] sh_q, rx_data_q;
    logic                 ferr_p_q, perr_p_q, done_q;
    logic                 rx_valid_q, frame_err_q, parity_err_q, overrun_q;

    always_comb begin
        tick   = div_q >= baud_div;
        div_d  = tick ? '0 : div_q + DIV_WIDTH'(1);
        fall   = rx_s_dly_q & ~rx_s_q;
        decide = tick && scnt_q == 4'd9;
        maj    = (smp_q[0] & smp_q[1]) | (smp_q[0] & rx_s_q) | (smp_q[1] & rx_s_q);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_m_q     <= 1'b1;
            rx_s_q     <= 1'b1;
            rx_s_dly_q <= 1'b1;
            div_q      <= '0;
        end else begin
            rx_m_q     <= rx;
            rx_s_q     <= rx_m_q;
            rx_s_dly_q <= rx_s_q;
            div_q      <= div_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            scnt_q       <= '0;
            bcnt_q       <= '0;
            smp_q        <= '0;
            sh_q         <= '0;
            ferr_p_q     <= 1'b0;
            perr_p_q     <= 1'b0;
            done_q       <= 1'b0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            overrun_q <= 1'b0;
            done_q    <= 1'b0;
            if (tick) scnt_q <= scnt_q + 4'd1;
            if (tick && scnt_q == 4'd7) smp_q[0] <= rx_s_q;
            if (tick && scnt_q == 4'd8) smp_q[1] <= rx_s_q;
            if (rx_valid_q && rx_ready) rx_valid_q <= 1'b0;
            // A finished word loads only into a free (or simultaneously drained) holding register
            if (done_q) begin
                if (!rx_valid_q || rx_ready) begin
                    rx_data_q    <= sh_q;
                    frame_err_q  <= ferr_p_q;
                    parity_err_q <= perr_p_q;
                    rx_valid_q   <= 1'b1;
                end else begin
                    overrun_q <= 1'b1;
                end
            end
            case (state_q)
                IDLE: if (fall) begin
                    scnt_q  <= '0;
                    state_q <= START;
                end
                START: if (decide) begin
                    bcnt_q   <= '0;
                    ferr_p_q <= 1'b0;
                    perr_p_q <= 1'b0;
                    state_q  <= maj ? IDLE : DATA;
                end
                DATA: if (decide) begin
                    sh_q   <= {maj, sh_q[DATA_BITS-1:1]};
                    bcnt_q <= bcnt_q + 4'd1;
                    if (bcnt_q == 4'(DATA_BITS - 1)) begin
                        bcnt_q  <= '0;
                        state_q <= (PARITY_EN != 0) ? PARITY : STOP;
                    end
                end
                PARITY: if (decide) begin
                    perr_p_q <= maj != ((^sh_q) ^ 1'(PARITY_ODD));
                    state_q  <= STOP;
                end
                STOP: if (decide) begin
                    if (!maj) ferr_p_q <= 1'b1;
                    bcnt_q <= bcnt_q + 4'd1;
                    // Return to IDLE mid stop bit so the next start edge can resync
                    if (bcnt_q == 4'(STOP_BITS - 1)) begin
                        bcnt_q  <= '0;
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign frame_err   = frame_err_q;
    assign parity_err  = parity_err_q;
    assign overrun_err = overrun_q;
    assign busy        = state_q != IDLE;
endmodule
